// File: rtl/noc_packet_tx.sv
// NoC packet transmitter: turns one request into a header flit followed by
// req_len payload flits, through a single registered output stage.
module noc_packet_tx #(
    parameter int FLIT_WIDTH  = 32,
    parameter int DEST_WIDTH  = 5,
    parameter int CLASS_WIDTH = 3,
    parameter int SRC_ID      = 0,
    parameter int MAX_LEN     = 16,
    localparam int LW         = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DEST_WIDTH-1:0]  req_dest,
    input  logic [CLASS_WIDTH-1:0] req_class,
    input  logic [LW-1:0]          req_len,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [FLIT_WIDTH-1:0]  data_flit,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic [FLIT_WIDTH-1:0]  out_flit,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   err_len,
    output logic [15:0]            pkt_count
);

    typedef enum logic {
        S_IDLE,
        S_PAYLOAD
    } state_e;

    state_e                  state_q;
    logic [FLIT_WIDTH-1:0]   out_flit_q;
    logic                    out_last_q;
    logic                    out_valid_q;
    logic [LW-1:0]           remaining_q;
    logic                    err_len_q;
    logic [15:0]             pkt_count_q;

    logic                    ofree;
    logic                    req_hs;
    logic                    data_hs;
    logic                    len_over_d;
    logic [LW-1:0]           len_eff_d;
    logic [FLIT_WIDTH-1:0]   header_d;

    // The slot can take a new flit when empty or when its flit leaves this cycle.
    assign ofree      = ~out_valid_q | out_ready;
    assign req_ready  = rst & (state_q == S_IDLE) & ofree;
    assign data_ready = rst & (state_q == S_PAYLOAD) & ofree;
    assign req_hs     = req_valid & req_ready;
    assign data_hs    = data_valid & data_ready;

    assign len_over_d = req_len > LW'(MAX_LEN);
    assign len_eff_d  = len_over_d ? LW'(MAX_LEN) : req_len;

    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        header_d = '0;
        header_d[FLIT_WIDTH-1 -: DEST_WIDTH]                         = req_dest;
        header_d[FLIT_WIDTH-1-DEST_WIDTH -: CLASS_WIDTH]             = req_class;
        header_d[FLIT_WIDTH-1-DEST_WIDTH-CLASS_WIDTH -: DEST_WIDTH]  = DEST_WIDTH'(SRC_ID);
        header_d[LW-1:0]                                             = len_eff_d;
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            out_flit_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            remaining_q <= '0;
            err_len_q   <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            err_len_q <= req_hs & len_over_d;
            if (req_hs) begin
                out_flit_q  <= header_d;
                out_last_q  <= (len_eff_d == '0);
                out_valid_q <= 1'b1;
                remaining_q <= len_eff_d;
                if (len_eff_d == '0) begin
                    pkt_count_q <= pkt_count_q + 16'd1;
                end else begin
                    state_q <= S_PAYLOAD;
                end
            end else if (data_hs) begin
                out_flit_q  <= data_flit;
                out_last_q  <= (remaining_q == LW'(1));
                out_valid_q <= 1'b1;
                remaining_q <= remaining_q - LW'(1);
                if (remaining_q == LW'(1)) begin
                    state_q     <= S_IDLE;
                    pkt_count_q <= pkt_count_q + 16'd1;
                end
            end else if (out_ready) begin
                // Flit consumed with nothing to replace it: empty the slot.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_flit  = out_flit_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == S_PAYLOAD);
    assign err_len   = err_len_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_noc_packet_tx.sv
// Randomized directed bench for noc_packet_tx: requests and payload words come
// from queues, and the expected flit stream is built from the packet rules.
module tb_noc_packet_tx;

    localparam int FW  = 32;
    localparam int DW  = 5;
    localparam int CW  = 3;
    localparam int ML  = 16;
    localparam int LW  = $clog2(ML + 1);
    localparam int SRC = 9;

    typedef struct {
        logic [DW-1:0] dest;
        logic [CW-1:0] cls;
        logic [LW-1:0] len;
    } req_t;

    typedef struct {
        logic [FW:0] w;     // {last, flit}
        int          cyc;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] req_dest;
    logic [CW-1:0] req_class;
    logic [LW-1:0] req_len;
    logic          req_valid;
    logic          req_ready;
    logic [FW-1:0] data_flit;
    logic          data_valid;
    logic          data_ready;
    logic [FW-1:0] out_flit;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          err_len;
    logic [15:0]   pkt_count;

    int n_checks = 0;
    int n_pass   = 0;

    req_t          req_q[$];
    logic [FW-1:0] data_q[$];
    logic [FW:0]   exp_q[$];
    obs_t          got_q[$];
    int            exp_pkts = 0;
    int            exp_err  = 0;
    int            err_cnt  = 0;
    int            cyc      = 0;
    int            req_cyc0 = -1;
    logic          busy_seen = 1'b0;
    logic          stall_q   = 1'b0;
    logic [FW:0]   stall_word;

    noc_packet_tx #(
        .FLIT_WIDTH (FW),
        .DEST_WIDTH (DW),
        .CLASS_WIDTH(CW),
        .SRC_ID     (SRC),
        .MAX_LEN    (ML)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_dest  (req_dest),
        .req_class (req_class),
        .req_len   (req_len),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .data_flit (data_flit),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err_len   (err_len),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Output monitor: records every flit that leaves and checks held flits under stall.
    always @(negedge clk) begin
        if (!rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_flit", 64'({out_last, out_flit}), 64'(stall_word));
            end
            if (out_valid && out_ready) got_q.push_back('{w: {out_last, out_flit}, cyc: cyc});
            if (err_len) err_cnt++;
            if (busy) busy_seen = 1'b1;
            stall_q    = out_valid && !out_ready;
            stall_word = {out_last, out_flit};
        end
    end

    function automatic logic [FW-1:0] header_of(input req_t r);
        int len_eff;
        len_eff = (int'(r.len) > ML) ? ML : int'(r.len);
        return (32'(r.dest) << 27) | (32'(r.cls) << 24) | (32'(SRC) << 19) | 32'(len_eff);
    endfunction

    task automatic add_pkt(input int dest, input int cls, input int len);
        req_t r;
        int   len_eff;
        logic [FW-1:0] w;
        r.dest  = DW'(dest);
        r.cls   = CW'(cls);
        r.len   = LW'(len);
        len_eff = (len > ML) ? ML : len;
        req_q.push_back(r);
        exp_q.push_back({(len_eff == 0), header_of(r)});
        for (int i = 0; i < len_eff; i++) begin
            w = $urandom;
            data_q.push_back(w);
            exp_q.push_back({(i == len_eff - 1), w});
        end
        if (len > ML) exp_err++;
        exp_pkts++;
    endtask

    // Drive until stop_at flits have left (0 = all expected flits) or the budget expires.
    task automatic run(input int ready_pct, input int data_pct, input int budget, input int stop_at);
        logic rhs, dhs;
        int   target;
        target   = (stop_at > 0) ? stop_at : exp_q.size();
        req_cyc0 = -1;
        for (int c = 0; c < budget && got_q.size() < target; c++) begin
            req_valid = req_q.size() > 0;
            if (req_valid) begin
                req_dest  = req_q[0].dest;
                req_class = req_q[0].cls;
                req_len   = req_q[0].len;
            end
            data_valid = (data_q.size() > 0) && ($urandom_range(99) < data_pct);
            data_flit  = (data_q.size() > 0) ? data_q[0] : $urandom;
            out_ready  = $urandom_range(99) < ready_pct;
            @(negedge clk);
            rhs = req_valid && req_ready;
            dhs = data_valid && data_ready;
            if (rhs && req_cyc0 < 0) req_cyc0 = cyc;
            @(posedge clk);
            #1;
            if (rhs) void'(req_q.pop_front());
            if (dhs) void'(data_q.pop_front());
        end
        req_valid  = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic verify(input string tag, input logic contig);
        int n;
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_flit"}, 64'(got_q[i].w), 64'(exp_q[i]));
        if (contig)
            for (int i = 1; i < n; i++) check({tag, "_gap"}, 64'(got_q[i].cyc - got_q[i-1].cyc), 64'd1);
        check({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkts));
        check({tag, "_err_len"}, 64'(err_cnt), 64'(exp_err));
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        req_dest   = '0;
        req_class  = '0;
        req_len    = '0;
        req_valid  = 1'b0;
        data_flit  = '0;
        data_valid = 1'b0;
        out_ready  = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_flit", 64'(out_flit), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_data_ready", 64'(data_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_len", 64'(err_len), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Basic packet: header, A, B back to back; header one cycle after acceptance.
        busy_seen = 1'b0;
        add_pkt(3, 1, 2);
        run(100, 100, 50, 0);
        check("t1_latency", 64'(got_q.size() > 0 ? got_q[0].cyc : -1), 64'(req_cyc0 + 1));
        check("t1_busy_seen", 64'(busy_seen), 64'd1);
        verify("t1", 1'b1);

        // Zero-length packet: lone header with last, never busy.
        busy_seen = 1'b0;
        add_pkt(17, 6, 0);
        run(100, 100, 50, 0);
        check("t2_busy_seen", 64'(busy_seen), 64'd0);
        verify("t2", 1'b1);

        // Two back-to-back len-3 packets: eight flits without a gap.
        add_pkt(5, 2, 3);
        add_pkt(30, 7, 3);
        run(100, 100, 80, 0);
        verify("t3", 1'b1);

        // Full-length packet under random backpressure.
        add_pkt(12, 4, ML);
        run(50, 100, 400, 0);
        verify("t4", 1'b0);

        // Oversized request: clamped to MAX_LEN with one err_len pulse.
        add_pkt(21, 3, ML + 5);
        run(70, 80, 400, 0);
        verify("t5", 1'b0);

        // Random packet mix with backpressure and gaps in the data stream.
        for (int i = 0; i < 6; i++) add_pkt($urandom_range(31), $urandom_range(7), $urandom_range(ML + 3));
        run(60, 70, 3000, 0);
        verify("t6", 1'b0);

        // Reset mid-payload after header + 2 of 4 payload flits have left.
        add_pkt(8, 5, 4);
        run(100, 100, 50, 3);
        rst = 1'b0;
        #1;
        check("t7_rst_out_valid", 64'(out_valid), 64'd0);
        check("t7_rst_busy", 64'(busy), 64'd0);
        check("t7_rst_pkt_count", 64'(pkt_count), 64'd0);
        req_q.delete();
        data_q.delete();
        exp_q.delete();
        got_q.delete();
        exp_pkts = 0;
        exp_err  = 0;
        err_cnt  = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        add_pkt(14, 2, 1);
        run(100, 100, 50, 0);
        verify("t7", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
